hd44780_sequencer: RTL and testbench

HD44780_SEQUENCER -- requirements
Module: hd44780_sequencer

---
 rtl/hd44780_pkg.sv | 53 +++++
 rtl/hd44780_delay_timer.sv | 31 +++
 rtl/hd44780_sequencer.sv | 139 +++++++++++++
 tb/tb_hd44780_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/hd44780_pkg.sv
// Shared definitions for the HD44780 sequencer: FSM state encoding, LCD command
// constants, the fixed power-on init ROM and wait-time helpers.
package hd44780_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP_WAIT,
    ST_INIT_ISSUE,
    ST_INIT_WAIT,
    ST_IDLE,
    ST_ISSUE,
    ST_EXEC_WAIT
  } state_e;

  // LCD command bytes
  localparam logic [7:0] CMD_CLEAR        = 8'h01;
  localparam logic [7:0] CMD_HOME         = 8'h02;
  localparam logic [7:0] CMD_FUNC_8B_2L   = 8'h38;
  localparam logic [7:0] CMD_DISP_ON      = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_INC    = 8'h06;

  // Init ROM geometry
  localparam int unsigned INIT_LEN   = 6;
  localparam int unsigned INIT_IDX_W = 3;
  localparam logic [INIT_IDX_W-1:0] INIT_LAST = INIT_IDX_W'(INIT_LEN - 1);

  // Shortest wait: covers the two-cycle E pulse downstream plus margin
  localparam int unsigned MIN_WAIT_CYC = 4;

  // Power-on init sequence: function set x3, display on, clear, entry mode
  function automatic logic [7:0] init_cmd(input logic [INIT_IDX_W-1:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: return CMD_FUNC_8B_2L;
      3'd3:             return CMD_DISP_ON;
      3'd4:             return CMD_CLEAR;
      3'd5:             return CMD_ENTRY_INC;
      default:          return 8'h00;
    endcase
  endfunction

  // Microseconds to clock cycles, floored at MIN_WAIT_CYC
  function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                               input int unsigned us);
    int unsigned c;
    c = (clk_hz / 32'd1000000) * us;
    return (c < MIN_WAIT_CYC) ? MIN_WAIT_CYC : c;
  endfunction

  // Clear (0x01) and home (0x02, 0x03 since DB0 is don't-care) need the long wait
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] db);
    return !rs && (db == CMD_CLEAR || db == CMD_HOME || db == (CMD_CLEAR | CMD_HOME));
  endfunction

endpackage

// File: rtl/hd44780_delay_timer.sv
// Down-counting wait timer.
// Ports: i_clk/i_reset (async active-high), i_start loads i_load into the counter,
// o_done_c is a combinational one-cycle pulse on the last cycle of the wait
// (counter == 1). A wait of N cycles measured from the cycle i_start is high
// therefore needs i_load = N-1.
module hd44780_delay_timer #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [W-1:0] i_load,
  output logic         o_done_c
);

  logic [W-1:0] r_cnt;

  // Load on start, otherwise count down and park at zero
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= i_load;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done_c = (r_cnt == W'(1));

endmodule

// File: rtl/hd44780_sequencer.sv
// HD44780 command/data sequencer (8-bit mode). After reset it waits the power-up
// time, plays the fixed init sequence, then accepts one client byte at a time and
// holds the bus through the command's execution time.
// Ports: i_clk, i_reset (async active-high); client i_valid/i_rs/i_byte with
// o_ready handshake; downstream o_ena strobe, o_rs, o_db[7:0]; o_init_done.
module hd44780_sequencer
  import hd44780_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 12000000,
  parameter int unsigned POWERUP_US   = 20000,
  parameter int unsigned EXEC_US      = 50,
  parameter int unsigned LONG_EXEC_US = 2000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  input  logic       i_rs,
  input  logic [7:0] i_byte,
  output logic       o_ready,
  output logic       o_ena,
  output logic       o_rs,
  output logic [7:0] o_db,
  output logic       o_init_done
);

  localparam int unsigned PU_CYC   = us_to_cycles(CLK_HZ, POWERUP_US);
  localparam int unsigned EXEC_CYC = us_to_cycles(CLK_HZ, EXEC_US);
  localparam int unsigned LONG_CYC = us_to_cycles(CLK_HZ, LONG_EXEC_US);
  localparam int unsigned MAX_CYC  = (PU_CYC > LONG_CYC)
                                     ? ((PU_CYC > EXEC_CYC) ? PU_CYC : EXEC_CYC)
                                     : ((LONG_CYC > EXEC_CYC) ? LONG_CYC : EXEC_CYC);
  localparam int unsigned CNT_W    = $clog2(MAX_CYC + 1);

  state_e                  r_state;
  logic [INIT_IDX_W-1:0]   r_idx;
  logic                    r_ena;
  logic                    r_rs;
  logic [7:0]              r_db;
  logic                    r_ready;
  logic                    r_init_done;
  logic                    r_tmr_start;
  logic [CNT_W-1:0]        r_tmr_load;

  logic                    w_tmr_done;
  logic [INIT_IDX_W-1:0]   w_next_idx;
  logic [7:0]              w_next_cmd;

  // Timer load for a command: the wait includes the o_ena cycle, and the
  // registered start costs one cycle, hence cycles-1.
  function automatic logic [CNT_W-1:0] exec_load(input logic rs, input logic [7:0] db);
    return is_long_cmd(rs, db) ? CNT_W'(LONG_CYC - 1) : CNT_W'(EXEC_CYC - 1);
  endfunction

  assign w_next_idx = r_idx + INIT_IDX_W'(1);
  assign w_next_cmd = init_cmd(w_next_idx);

  hd44780_delay_timer #(.W(CNT_W)) u_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_start  (r_tmr_start),
    .i_load   (r_tmr_load),
    .o_done_c (w_tmr_done)
  );

  // Sequencer FSM. The start strobe comes out of reset already armed with the
  // power-up wait so the first init command issues PU_CYC cycles after release.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_POWERUP_WAIT;
      r_idx       <= '0;
      r_ena       <= 1'b0;
      r_rs        <= 1'b0;
      r_db        <= 8'h00;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
      r_tmr_start <= 1'b1;
      r_tmr_load  <= CNT_W'(PU_CYC - 1);
    end else begin
      r_ena       <= 1'b0;
      r_tmr_start <= 1'b0;
      case (r_state)
        ST_POWERUP_WAIT: begin
          if (w_tmr_done) begin
            r_idx       <= '0;
            r_rs        <= 1'b0;
            r_db        <= init_cmd(INIT_IDX_W'(0));
            r_ena       <= 1'b1;
            r_tmr_start <= 1'b1;
            r_tmr_load  <= exec_load(1'b0, init_cmd(INIT_IDX_W'(0)));
            r_state     <= ST_INIT_ISSUE;
          end
        end
        ST_INIT_ISSUE: r_state <= ST_INIT_WAIT;
        ST_INIT_WAIT: begin
          if (w_tmr_done) begin
            if (r_idx == INIT_LAST) begin
              r_ready     <= 1'b1;
              r_init_done <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_idx       <= w_next_idx;
              r_db        <= w_next_cmd;
              r_ena       <= 1'b1;
              r_tmr_start <= 1'b1;
              r_tmr_load  <= exec_load(1'b0, w_next_cmd);
              r_state     <= ST_INIT_ISSUE;
            end
          end
        end
        ST_IDLE: begin
          if (i_valid && r_ready) begin
            r_rs        <= i_rs;
            r_db        <= i_byte;
            r_ena       <= 1'b1;
            r_ready     <= 1'b0;
            r_tmr_start <= 1'b1;
            r_tmr_load  <= exec_load(i_rs, i_byte);
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: r_state <= ST_EXEC_WAIT;
        ST_EXEC_WAIT: begin
          if (w_tmr_done) begin
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_POWERUP_WAIT;
      endcase
    end
  end

  assign o_ready     = r_ready;
  assign o_ena       = r_ena;
  assign o_rs        = r_rs;
  assign o_db        = r_db;
  assign o_init_done = r_init_done;

endmodule

// File: tb/tb_hd44780_sequencer.sv
// Directed bench for hd44780_sequencer at 1 MHz: power-up 100, exec 5, long 20 cycles.
module tb_hd44780_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic       rs_in;
  logic [7:0] byte_in;
  logic       ready;
  logic       ena;
  logic       rs;
  logic [7:0] db;
  logic       init_done;

  int   n_cmp      = 0;
  int   n_err      = 0;
  int   ena_cnt    = 0;
  int   consec_cnt = 0;
  logic prev_ena   = 1'b0;

  always #5 clk = ~clk;

  hd44780_sequencer #(
    .CLK_HZ       (1000000),
    .POWERUP_US   (100),
    .EXEC_US      (5),
    .LONG_EXEC_US (20)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_valid     (valid),
    .i_rs        (rs_in),
    .i_byte      (byte_in),
    .o_ready     (ready),
    .o_ena       (ena),
    .o_rs        (rs),
    .o_db        (db),
    .o_init_done (init_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobe monitor: total pulses and back-to-back pulses
  always @(negedge clk) begin
    if (ena === 1'b1) begin
      ena_cnt++;
      if (prev_ena === 1'b1) consec_cnt++;
    end
    prev_ena = ena;
  end

  // Called at the negedge right after reset release; returns at the negedge where
  // o_init_done is first seen high.
  task automatic run_init(input string pfx);
    logic [7:0] cmds [6];
    int         waits [6];
    int         n;
    logic       held;
    logic       stop;
    cmds  = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    waits = '{5, 5, 5, 5, 20, 5};
    n = 0;
    while (ena !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s_first_ena_cycle(%0d)", pfx, n), 32'((n >= 99) && (n <= 101)), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("%s_cmd%0d_db", pfx, i), 32'(db), 32'(cmds[i]));
      chk($sformatf("%s_cmd%0d_rs", pfx, i), 32'(rs), 32'd0);
      chk($sformatf("%s_cmd%0d_init_done", pfx, i), 32'(init_done), 32'd0);
      n    = 0;
      held = 1'b1;
      stop = 1'b0;
      while (!stop && n < 100) begin
        @(negedge clk);
        n++;
        stop = (i < 5) ? (ena === 1'b1) : (init_done === 1'b1);
        if (!stop && (db !== cmds[i] || rs !== 1'b0)) held = 1'b0;
      end
      chk($sformatf("%s_cmd%0d_wait", pfx, i), 32'(n), 32'(waits[i]));
      chk($sformatf("%s_cmd%0d_held", pfx, i), 32'(held), 32'd1);
    end
    chk({pfx, "_init_done"}, 32'(init_done), 32'd1);
    chk({pfx, "_ready_after_init"}, 32'(ready), 32'd1);
  endtask

  // Called at a negedge with o_ready high; returns at the negedge where it is high again.
  task automatic send(input string tag, input logic r, input logic [7:0] b, input int exp_low);
    int   low;
    int   ena0;
    logic held;
    ena0    = ena_cnt;
    valid   = 1'b1;
    rs_in   = r;
    byte_in = b;
    @(negedge clk);
    valid   = 1'b0;
    byte_in = ~b;
    chk({tag, "_ena"}, 32'(ena), 32'd1);
    chk({tag, "_rs"}, 32'(rs), 32'(r));
    chk({tag, "_db"}, 32'(db), 32'(b));
    low  = 0;
    held = 1'b1;
    while (ready !== 1'b1 && low < 200) begin
      low++;
      if (db !== b || rs !== r) held = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_ready_low_cycles"}, 32'(low), 32'(exp_low));
    chk({tag, "_bus_held"}, 32'(held), 32'd1);
    chk({tag, "_ena_pulses"}, 32'(ena_cnt - ena0), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] got [3];
    int         ng;
    int         ena0;
    int         n;

    rst     = 1'b1;
    valid   = 1'b0;
    rs_in   = 1'b0;
    byte_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ena",       32'(ena),       32'd0);
    chk("rst_rs",        32'(rs),        32'd0);
    chk("rst_db",        32'(db),        32'd0);
    chk("rst_ready",     32'(ready),     32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    rst = 1'b0;

    run_init("init");

    send("data41", 1'b1, 8'h41, 5);
    send("clear", 1'b0, 8'h01, 20);

    // i_valid held with a new byte each cycle: only bytes seen with o_ready high issue
    ena0    = ena_cnt;
    ng      = 0;
    valid   = 1'b1;
    rs_in   = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (k > 0 && ena === 1'b1) begin
        if (ng < 3) got[ng] = db;
        ng++;
      end
      if (k < 14) byte_in = 8'(8'h50 + k);
      else        valid   = 1'b0;
      @(negedge clk);
    end
    n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("burst_ena_count", 32'(ng), 32'd3);
    chk("burst_b0", 32'(got[0]), 32'h50);
    chk("burst_b1", 32'(got[1]), 32'h56);
    chk("burst_b2", 32'(got[2]), 32'h5C);
    chk("burst_monitor_pulses", 32'(ena_cnt - ena0), 32'd3);
    chk("burst_ready_back", 32'(ready), 32'd1);

    // Reset in the middle of an execution wait
    valid   = 1'b1;
    rs_in   = 1'b1;
    byte_in = 8'h42;
    @(negedge clk);
    valid = 1'b0;
    chk("midrst_pre_ena", 32'(ena), 32'd1);
    chk("midrst_pre_db", 32'(db), 32'h42);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ena",       32'(ena),       32'd0);
    chk("midrst_rs",        32'(rs),        32'd0);
    chk("midrst_db",        32'(db),        32'd0);
    chk("midrst_ready",     32'(ready),     32'd0);
    chk("midrst_init_done", 32'(init_done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_init("reinit");

    repeat (3) @(negedge clk);
    chk("total_ena_pulses", 32'(ena_cnt), 32'd18);
    chk("consecutive_ena", 32'(consec_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
